// File: rtl/lab4_branch_pkg.sv
// Shared types and constants for the branch resolve queue slice.
package lab4_branch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } bq_entry_t;

  localparam logic [31:0] BQ_PC_INCR = 32'd4;

endpackage

// File: rtl/lab4_branch_BranchResolveFifo.sv
// Circular buffer of in-flight branch entries with a head read port and a flush
// that drops everything, including an enqueue arriving in the same cycle.
module lab4_branch_BranchResolveFifo
  import lab4_branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq,
  input  bq_entry_t                enq_data,
  input  logic                     deq,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output bq_entry_t                head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bq_entry_t         mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[head];

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[tail] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction tracker: resolves the oldest branch, drives the
// predictor update port and a registered mispredict redirect that flushes the queue.
module branch_resolve_queue
  import lab4_branch_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enq_val,
  output logic                          enq_rdy,
  input  logic [31:0]                   enq_pc,
  input  logic                          enq_pred,
  input  logic [31:0]                   enq_target,
  input  logic                          res_val,
  output logic                          res_rdy,
  input  logic                          res_taken,
  input  logic [31:0]                   res_target,
  output logic                          update_en,
  output logic                          update_val,
  output logic [31:0]                   update_pc,
  output logic                          mispred_val,
  output logic [31:0]                   mispred_pc,
  output logic [$clog2(NUM_ENTRIES):0]  count
);
  bq_entry_t   enq_data;
  bq_entry_t   head;
  logic        full;
  logic        empty;
  logic        enq_fire;
  logic        res_fire;
  logic        mispred;
  logic [31:0] redirect;

  assign enq_data = '{pc: enq_pc, pred: enq_pred, target: enq_target};
  assign enq_rdy  = !full;
  assign res_rdy  = !empty;
  assign enq_fire = enq_val && enq_rdy;
  assign res_fire = res_val && res_rdy;

  // Target only matters when both prediction and outcome say taken.
  assign mispred  = (res_taken != head.pred) ||
                    (res_taken && head.pred && (res_target != head.target));
  assign redirect = res_taken ? res_target : head.pc + BQ_PC_INCR;

  lab4_branch_BranchResolveFifo #(.DEPTH(NUM_ENTRIES)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq_fire),
    .enq_data  (enq_data),
    .deq       (res_fire),
    .flush     (res_fire && mispred),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .head_data (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      update_en   <= 1'b0;
      update_val  <= 1'b0;
      update_pc   <= '0;
      mispred_val <= 1'b0;
      mispred_pc  <= '0;
    end else begin
      update_en   <= res_fire;
      mispred_val <= res_fire && mispred;
      if (res_fire) begin
        update_val <= res_taken;
        update_pc  <= head.pc;
      end
      if (res_fire && mispred) mispred_pc <= redirect;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a scoreboard of expected
// predictor updates / redirects checked by an independent monitor.
module tb_branch_resolve_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        enq_val, enq_pred, res_val, res_taken;
  logic [31:0] enq_pc, enq_target, res_target;
  logic        enq_rdy, res_rdy, update_en, update_val, mispred_val;
  logic [31:0] update_pc, mispred_pc;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        val;
    logic [31:0] pc;
    logic        mis;
    logic [31:0] mpc;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  branch_resolve_queue #(.NUM_ENTRIES(4)) dut (
    .clk(clk), .reset(reset),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_pc(enq_pc),
    .enq_pred(enq_pred), .enq_target(enq_target),
    .res_val(res_val), .res_rdy(res_rdy), .res_taken(res_taken),
    .res_target(res_target),
    .update_en(update_en), .update_val(update_val), .update_pc(update_pc),
    .mispred_val(mispred_val), .mispred_pc(mispred_pc), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every update strobe must match the oldest expected resolve.
  always @(negedge clk) begin
    if (update_en) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_update: got pc %h expected no strobe", update_pc);
      end else begin
        e = sbq.pop_front();
        chk("update_val", {31'd0, update_val}, {31'd0, e.val});
        chk("update_pc", update_pc, e.pc);
        chk("mispred_val", {31'd0, mispred_val}, {31'd0, e.mis});
        if (e.mis) chk("mispred_pc", mispred_pc, e.mpc);
      end
    end else if (mispred_val) begin
      n_cmp++; n_bad++;
      $display("FAIL lone_mispred: got mispred_val 1 expected 0");
    end
  end

  task automatic cyc(input logic ev, input logic [31:0] pc, input logic pred,
                     input logic [31:0] tgt, input logic rv, input logic rt,
                     input logic [31:0] rtgt);
    enq_val = ev; enq_pc = pc; enq_pred = pred; enq_target = tgt;
    res_val = rv; res_taken = rt; res_target = rtgt;
    @(posedge clk);
    #1;
    enq_val = 0; res_val = 0; res_taken = 0;
    enq_pc = '0; enq_pred = 0; enq_target = '0; res_target = '0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    cyc(1'b1, pc, pred, tgt, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_res(input logic v, input logic [31:0] pc, input logic m,
                            input logic [31:0] mpc);
    exp_t x;
    x.val = v; x.pc = pc; x.mis = m; x.mpc = mpc;
    sbq.push_back(x);
  endtask

  task automatic chk_count(input string nm, input int exp);
    @(negedge clk);
    chk(nm, {29'd0, count}, 32'(exp));
  endtask

  initial begin
    reset = 1; enq_val = 0; res_val = 0; res_taken = 0; enq_pred = 0;
    enq_pc = '0; enq_target = '0; res_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    chk("rst_res_rdy", {31'd0, res_rdy}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_update_en", {31'd0, update_en}, 32'd0);
    chk("rst_update_pc", update_pc, 32'd0);
    chk("rst_mispred_pc", mispred_pc, 32'd0);

    // Fill, then offer a fifth entry that must be refused.
    for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4 * i), 1'b0, '0);
    @(negedge clk);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_enq_rdy", {31'd0, enq_rdy}, 32'd0);
    enq(32'h110, 1'b0, '0);
    chk_count("fifth_refused", 4);

    expect_res(1'b0, 32'h100, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk_count("after_res1", 3);
    for (int i = 1; i < 4; i++) begin
      expect_res(1'b0, 32'h100 + 32'(4 * i), 1'b0, '0);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    end
    chk_count("drained", 0);

    // Taken/taken with wrong target.
    enq(32'h200, 1'b1, 32'h300);
    expect_res(1'b1, 32'h200, 1'b1, 32'h340);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h340);
    @(negedge clk);
    chk("tgt_mis_res_rdy", {31'd0, res_rdy}, 32'd0);

    // Predicted taken, not taken, with a wrong-path enqueue in the same cycle.
    enq(32'h400, 1'b1, 32'h480);
    expect_res(1'b0, 32'h400, 1'b1, 32'h404);
    cyc(1'b1, 32'h500, 1'b0, '0, 1'b1, 1'b0, '0);
    chk_count("wrong_path_dropped", 0);

    // Correct taken/taken with matching target, then not-taken predicted but taken.
    enq(32'h600, 1'b1, 32'h700);
    enq(32'h620, 1'b0, '0);
    expect_res(1'b1, 32'h600, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h700);
    expect_res(1'b1, 32'h620, 1'b1, 32'h800);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h800);
    chk_count("dir_mis_empty", 0);

    // Full queue: correct resolve with an enqueue offered; enqueue refused.
    for (int i = 0; i < 4; i++) enq(32'h1000 + 32'(4 * i), 1'b0, '0);
    expect_res(1'b0, 32'h1000, 1'b0, '0);
    cyc(1'b1, 32'h2000, 1'b0, '0, 1'b1, 1'b0, '0);
    chk_count("full_no_bypass", 3);
    for (int i = 1; i < 4; i++) begin
      expect_res(1'b0, 32'h1000 + 32'(4 * i), 1'b0, '0);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    end

    // Pointer wrap with simultaneous enqueue and correct resolve.
    enq(32'h3000, 1'b0, '0);
    for (int i = 1; i <= 8; i++) begin
      expect_res(1'b0, 32'h3000 + 32'(4 * (i - 1)), 1'b0, '0);
      cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0, '0, 1'b1, 1'b0, '0);
      chk_count("wrap_count", 1);
    end
    expect_res(1'b0, 32'h3020, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);

    // Reset mid-operation with a resolve firing drops the pending strobe.
    for (int i = 0; i < 3; i++) enq(32'h4000 + 32'(4 * i), 1'b0, '0);
    reset = 1;
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_update_en", {31'd0, update_en}, 32'd0);
    chk("mid_rst_mispred", {31'd0, mispred_val}, 32'd0);
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_res_rdy", {31'd0, res_rdy}, 32'd0);
    chk("mid_rst_update_pc", update_pc, 32'd0);

    repeat (3) @(negedge clk);
    chk("pending_expected", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracker for branch predictions in flight between fetch and execute. Fetch enqueues each predicted branch (PC, predicted direction, predicted target). Execute resolves branches in program order with the actual outcome. The block drives the update port of the bimodal predictor (update_en / update_val / update_pc), and raises a registered mispredict redirect that flushes all younger in-flight entries.

## Interface
- NUM_ENTRIES, 4: queue depth; power of two, ≥ 2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enq_val  in  1  fetch offers a predicted branch.
- enq_rdy  out  1  queue accepts; equals !full.
- enq_pc  in  32  branch PC.
- enq_pred  in  1  predicted taken.
- enq_target  in  32  predicted target; meaningful only when enq_pred = 1.
- res_val  in  1  execute presents the outcome of the oldest branch.
- res_rdy  out  1  equals !empty.
- res_taken  in  1  actual direction.
- res_target  in  32  actual target; meaningful only when res_taken = 1.
- update_en  out  1  predictor update strobe.
- update_val  out  1  actual direction for the predictor.
- update_pc  out  32  PC indexing the predictor.
- mispred_val  out  1  redirect strobe.
- mispred_pc  out  32  redirect address.
- count  out  $clog2(NUM_ENTRIES)+1  current occupancy.

## Operation
- Circular buffer: head pointer, tail pointer, count. Pointers wrap modulo NUM_ENTRIES.
- Enqueue fires on enq_val && enq_rdy. It writes {pc, pred, target} at tail, then tail+1.
- Resolve fires on res_val && res_rdy. It dequeues head, then head+1.
- Mispredict when res_taken != head.pred, or when res_taken && head.pred && res_target != head.target.
- Redirect address: res_taken ? res_target : head.pc + 4 (32-bit wrap).
- On a mispredicting resolve, the queue empties at the next edge: head = tail, count = 0.
  - An enqueue firing in the same cycle is wrong-path and is discarded.
- On a correct resolve with a simultaneous enqueue, count is unchanged and both pointers advance.
- Every resolve fire produces one predictor update: update_en = 1, update_val = res_taken, update_pc = head.pc.
- A resolve never bypasses an enqueue from the same cycle; res_rdy is 0 while empty.

## Timing
- Reset values:
  - head = tail = 0, count = 0.
  - enq_rdy = 1, res_rdy = 0.
  - update_en = 0, update_val = 0, update_pc = 0.
  - mispred_val = 0, mispred_pc = 0.
- enq_rdy, res_rdy and count are functions of registered state only. No combinational path from enq_val or res_val.
- update_* and mispred_* are registered.
  - They are valid exactly one cycle after the resolve fire.
  - Each strobe is a single-cycle pulse and is 0 in any cycle not following a fire.
  - update_val, update_pc and mispred_pc hold their last value when the strobe is 0.
- Full: enq_rdy = 0 even if a resolve fires in the same cycle (no bypass).
- Empty: res_rdy = 0; res_val is ignored.
- Reset asserted mid-operation drops all entries and any pending strobes at that edge.
  - Outputs take their reset values the following cycle.

## Structure
- Shared package lab4_branch_pkg holds:
  - typedef bq_entry_t = {logic [31:0] pc; logic pred; logic [31:0] target}.
  - constant BQ_PC_INCR = 32'd4.
- One sub-module, lab4_branch_BranchResolveFifo: a parameterised circular buffer of bq_entry_t.
  - It has enq/deq ports, a flush input, count, and a head-entry read port.
  - The top level holds the mispredict compare, redirect mux and output registers.

## Test plan
- Reset, then 4 enqueues (pc 0x100, 0x104, 0x108, 0x10C; pred 0) -> count = 4, enq_rdy = 0. A 5th enq_val is not accepted.
- Resolve pc 0x100 with res_taken = 0 (correct) -> next cycle update_en = 1, update_val = 0, update_pc = 0x100, mispred_val = 0, count = 3.
- Head pc 0x200 with pred = 1, target 0x300; resolve res_taken = 1, res_target = 0x340 -> mispred_val = 1, mispred_pc = 0x340, update_val = 1. Queue empty next cycle.
- Head pc 0x400 with pred = 1; resolve res_taken = 0 with a simultaneous enqueue of 0x500 -> mispred_pc = 0x404, count = 0; the 0x500 entry is discarded.
- Full queue, correct resolve with enq_val = 1 -> enqueue refused. Then pointer wrap: 2×NUM_ENTRIES enqueue/resolve pairs return updates in FIFO order.
- Reset asserted with count = 3 and a resolve firing -> next cycle update_en = 0, mispred_val = 0, count = 0, res_rdy = 0.
